// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS field encodings, opcode constants and bit positions
package mips_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_BAD = 2'd3
  } fmt_e;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_DONE = 1'b1
  } ld_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;

endpackage

// File: rtl/ins_field_pack.sv
// rtl/ins_field_pack.sv - combinational packing of decoded fields into a 32-bit word
module ins_field_pack
  import mips_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] immediate,
  input  logic [25:0] address,
  output logic [31:0] word,
  output logic        legal
);

  fmt_e fmt_sel;
  assign fmt_sel = fmt_e'(fmt);

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (fmt_sel)
      FMT_R: begin
        // opcode field stays zero; the incoming opcode only gates legality
        word[RS_LSB +: 5]    = rs;
        word[RT_LSB +: 5]    = rt;
        word[RD_LSB +: 5]    = rd;
        word[SHAMT_LSB +: 5] = shamt;
        word[5:0]            = funct;
        legal                = (opcode == OP_RTYPE);
      end
      FMT_I: begin
        word[OPCODE_LSB +: 6] = opcode;
        word[RS_LSB +: 5]     = rs;
        word[RT_LSB +: 5]     = rt;
        word[15:0]            = immediate;
        legal                 = (opcode != OP_RTYPE) && (opcode != OP_J) && (opcode != OP_JAL);
      end
      FMT_J: begin
        word[OPCODE_LSB +: 6] = opcode;
        word[25:0]            = address;
        legal                 = (opcode == OP_J) || (opcode == OP_JAL);
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ins_encoder.sv
// rtl/ins_encoder.sv - loads packed instruction words into consecutive memory locations
module ins_encoder
  import mips_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [1:0]                         fmt,
  input  logic [5:0]                         opcode,
  input  logic [4:0]                         rs,
  input  logic [4:0]                         rt,
  input  logic [4:0]                         rd,
  input  logic [4:0]                         shamt,
  input  logic [5:0]                         funct,
  input  logic [15:0]                        immediate,
  input  logic [25:0]                        address,
  input  logic                               flush,
  output logic                               mem_we,
  output logic [31:0]                        mem_addr,
  output logic [31:0]                        mem_wdata,
  output logic [$clog2(DEPTH_WORDS+1)-1:0]   count,
  output logic                               done,
  output logic                               err
);

  localparam int            CW      = $clog2(DEPTH_WORDS + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH_WORDS);
  localparam logic [CW-1:0] LAST_C  = CW'(DEPTH_WORDS - 1);

  ld_state_e   state_q, state_d;
  logic [31:0] word;
  logic        legal;
  logic        accept;
  logic        write;

  ins_field_pack u_pack (
    .fmt       (fmt),
    .opcode    (opcode),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .funct     (funct),
    .immediate (immediate),
    .address   (address),
    .word      (word),
    .legal     (legal)
  );

  assign in_ready = !rst && (state_q == ST_LOAD) && (count < DEPTH_C);
  assign accept   = in_valid && in_ready;
  assign write    = accept && legal;
  assign done     = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    if (state_q == ST_LOAD) begin
      if (flush || (write && (count == LAST_C))) begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_LOAD;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_we  <= write;
      // address index comes from count as it stood at acceptance
      if (write) begin
        mem_addr  <= BASE_ADDR + (32'(count) << 2);
        mem_wdata <= word;
        count     <= count + 1'b1;
      end
      if (accept && !legal) begin
        err <= 1'b1;
      end
    end
  end

endmodule
